key_expansion_128: RTL and testbench

- Iterative AES-128 key schedule. Expands one 128-bit cipher key into the 11 round keys (round 0..10), producing one round key per clock.
- Sits directly upstream of encryption_128. It streams each round key as it is produced and holds all 11 in an internal store.
- The store has a registered read port that the encryption core (or a later decryption core) indexes by round number.

---
 rtl/key_expansion_128.sv | 123 ++++++++++++
 tb/tb_key_expansion_128.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: one round key per clock, with all 11 keys
// kept in a store that has a registered, round-indexed read port.
module key_expansion_128 #(
  parameter int N = 128,
  parameter int R = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [N-1:0] round_key,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_round,
  output logic [N-1:0] rd_key
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       r_state, w_next_state;
  logic [N-1:0] r_w;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_rk_valid, r_done;
  logic [N-1:0] r_round_key, r_rd_key;
  logic [N-1:0] r_store [0:R];

  logic         w_load, w_step, w_last;
  logic [31:0]  w_rot, w_temp, w_w0, w_w1, w_w2, w_w3;
  logic [N-1:0] w_next_key;
  logic [7:0]   w_rcon_next;

  // Capture is allowed from IDLE and READY; start during EXPAND is dropped.
  assign w_load = start && (r_state != EXPAND);
  assign w_step = (r_state == EXPAND);
  assign w_last = w_step && (r_round == 4'(R - 1));

  assign w_rot  = {r_w[23:0], r_w[31:24]};
  assign w_temp = {sbox(w_rot[31:24]) ^ r_rcon, sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_w0   = r_w[127:96] ^ w_temp;
  assign w_w1   = r_w[95:64]  ^ w_w0;
  assign w_w2   = r_w[63:32]  ^ w_w1;
  assign w_w3   = r_w[31:0]   ^ w_w2;
  assign w_next_key  = {w_w0, w_w1, w_w2, w_w3};
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, READY: if (start)  w_next_state = EXPAND;
      EXPAND:      if (w_last) w_next_state = READY;
      default:     w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w         <= '0;
      r_rcon      <= 8'h01;
      r_round     <= '0;
      r_rk_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_round_key <= '0;
      r_rd_key    <= '0;
      for (int i = 0; i <= R; i++) r_store[i] <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_load) begin
        r_w         <= key;
        r_round_key <= key;
        r_round     <= '0;
        r_rk_valid  <= 1'b1;
        r_rcon      <= 8'h01;
        r_store[0]  <= key;
      end else if (w_step) begin
        r_w         <= w_next_key;
        r_round_key <= w_next_key;
        r_round     <= r_round + 4'd1;
        r_rk_valid  <= 1'b1;
        r_rcon      <= w_rcon_next;
        r_done      <= w_last;
        r_store[r_round + 4'd1] <= w_next_key;
      end
      // Read samples pre-edge contents, so a same-edge write is not visible.
      if (rd_round <= 4'(R)) r_rd_key <= r_store[rd_round];
      else                   r_rd_key <= '0;
    end
  end

  assign busy       = (r_state == EXPAND);
  assign keys_ready = (r_state == READY);
  assign rk_valid   = r_rk_valid;
  assign rk_round   = r_round;
  assign round_key  = r_round_key;
  assign done       = r_done;
  assign rd_key     = r_rd_key;

endmodule

// File: tb/tb_key_expansion_128.sv
// Directed bench for key_expansion_128 using FIPS-197 and all-zero key vectors.
module tb_key_expansion_128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy, rk_valid, done, keys_ready;
  logic [3:0]   rk_round, rd_round;
  logic [127:0] round_key, rd_key;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips [0:10];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion_128 dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_round(rk_round), .round_key(round_key),
    .done(done), .keys_ready(keys_ready), .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  // Drive start for exactly one rising edge; returns at the negedge after capture.
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; key = '0; rd_round = 4'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, rk_valid, done, keys_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, rk_valid, done, keys_ready});
    end
    checks++;
    if (rk_round !== 4'd0 || round_key !== 128'h0) begin
      errors++; $display("FAIL reset_rk got round %0d key %h want 0/0", rk_round, round_key);
    end
    checks++;
    if (rd_key !== 128'h0) begin
      errors++; $display("FAIL reset_rd got %h want 0", rd_key);
    end
  endtask

  task automatic test_fips;
    pulse_start(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(i) || round_key !== fips[i]) begin
        errors++;
        $display("FAIL fips_round%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                 i, rk_valid, rk_round, round_key, i, fips[i]);
      end
      checks++;
      if (done !== (i == 10) || busy !== (i != 10) || keys_ready !== (i == 10)) begin
        errors++;
        $display("FAIL fips_ctl%0d got done=%b busy=%b ready=%b", i, done, busy, keys_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || done !== 1'b0 || keys_ready !== 1'b1 || round_key !== fips[10]) begin
      errors++;
      $display("FAIL fips_after got v=%b done=%b ready=%b k=%h", rk_valid, done, keys_ready, round_key);
    end
  endtask

  task automatic test_ignored_start;
    int dones = 0;
    pulse_start(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      if (done) dones++;
      if (i == 4) begin start = 1'b1; key = '0; end
      if (i == 5) start = 1'b0;
      checks++;
      if (rk_round !== 4'(i) || round_key !== fips[i]) begin
        errors++;
        $display("FAIL ign_round%0d got r=%0d k=%h want k=%h", i, rk_round, round_key, fips[i]);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ign_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_zero_key;
    pulse_start('0);
    checks++;
    if (rk_round !== 4'd0 || round_key !== 128'h0) begin
      errors++; $display("FAIL zero_r0 got r=%0d k=%h want 0/0", rk_round, round_key);
    end
    @(negedge clk);
    checks++;
    if (rk_round !== 4'd1 || round_key !== Z_R1) begin
      errors++; $display("FAIL zero_r1 got r=%0d k=%h want 1/%h", rk_round, round_key, Z_R1);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (rk_round !== 4'd10 || round_key !== Z_R10 || done !== 1'b1) begin
      errors++; $display("FAIL zero_r10 got r=%0d k=%h d=%b want 10/%h/1", rk_round, round_key, done, Z_R10);
    end
    rd_round = 4'd1;
    @(negedge clk);
    checks++;
    if (rd_key !== Z_R1) begin
      errors++; $display("FAIL zero_rd1 got %h want %h", rd_key, Z_R1);
    end
    rd_round = 4'd12;
    @(negedge clk);
    checks++;
    if (rd_key !== 128'h0) begin
      errors++; $display("FAIL zero_rd12 got %h want 0", rd_key);
    end
  endtask

  task automatic test_restart;
    checks++;
    if (keys_ready !== 1'b1) begin
      errors++; $display("FAIL restart_pre got ready=%b want 1", keys_ready);
    end
    pulse_start(FIPS_KEY);
    checks++;
    if (keys_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_drop got ready=%b busy=%b want 0/1", keys_ready, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (round_key !== fips[10] || keys_ready !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL restart_r10 got k=%h ready=%b done=%b", round_key, keys_ready, done);
    end
    rd_round = 4'd10;
    @(negedge clk);
    checks++;
    if (rd_key !== fips[10]) begin
      errors++; $display("FAIL restart_rd10 got %h want %h", rd_key, fips[10]);
    end
    rd_round = 4'd0;
  endtask

  task automatic test_reset_mid;
    pulse_start(FIPS_KEY);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || keys_ready !== 1'b0 || round_key !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b v=%b ready=%b k=%h", busy, rk_valid, keys_ready, round_key);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle got busy=%b v=%b want 0/0", busy, rk_valid);
    end
    pulse_start(FIPS_KEY);
    repeat (10) @(negedge clk);
    checks++;
    if (rk_round !== 4'd10 || round_key !== fips[10] || done !== 1'b1 || keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rerun got r=%0d k=%h done=%b ready=%b", rk_round, round_key, done, keys_ready);
    end
  endtask

  initial begin
    fips[0]  = FIPS_KEY;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset;
    test_fips;
    test_ignored_start;
    test_zero_key;
    test_restart;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
